rename_regfile_mp: RTL and testbench
====================================

Name: rename_regfile_mp

Overview:
- Parametrised successor to the two-port Tomasulo register file with a register status table.
- Holds architectural values plus a per-register "pending" tag naming the reservation station that will produce each register.
- Serves ISSUE_W issue slots (two sources and one destination each) and absorbs CDB_W common-data-bus channels.
- Adds behaviour the previous generation lacks:
  - same-cycle CDB bypass to the read ports;
  - intra-bundle dependency forwarding;
  - WAW re-rename of registers that are already pending;
  - hardwired zero register;
  - speculation flush;
  - pending-register count.

Parameters:
NUM_REGS, 32, number of architectural registers (power of two); ADDR_W = $clog2(NUM_REGS) is derived.
DATA_W, 32, register data width.
TAG_W, 8, tag width; must be <= DATA_W; tag value 0 is reserved and means "no producer".
ISSUE_W, 2, issue slots per cycle; slot 0 is oldest in program order.
CDB_W, 3, CDB broadcast channels.
ZERO_REG, 1, 1: register 0 always reads 0 and is never renamed.
BYPASS, 1, 1: a read hit on a CDB tag in the same cycle returns the CDB data.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
en  in  1  state-update enable
flush  in  1  speculation recovery
slot_valid  in  ISSUE_W  per-slot instruction valid
addr_rs1, addr_rs2, addr_rd  in  ISSUE_W*ADDR_W  flattened source and destination addresses; slot k occupies bits [k*ADDR_W +: ADDR_W]
rd_tag  in  ISSUE_W*TAG_W  tag allocated to each slot's destination
dout_rs1, dout_rs2  out  ISSUE_W*DATA_W  operand value, or tag zero-extended
dtype_rs1, dtype_rs2  out  ISSUE_W  0 = data, 1 = tag
cdb_valid  in  CDB_W  per-channel broadcast valid
cdb_tag  in  CDB_W*TAG_W  broadcast tags
cdb_data  in  CDB_W*DATA_W  broadcast data
pending_count  out  $clog2(NUM_REGS+1)  number of registers with valid=0

Behaviour:
State per register: data[DATA_W], valid, tag[TAG_W].

Reset (synchronous): every register i gets data = i truncated to DATA_W, valid = 1, tag = 0. After reset:
- all read outputs are combinational from that state;
- pending_count = 0.

Update priority: reset > flush > en. With en = 0 and flush = 0, state holds; reads still operate.

Flush: for every register, valid <= 1 and tag <= 0; data is retained. Issue and CDB inputs are ignored in the flush cycle.

Reads (combinational, zero latency). For slot k and each source s, the first matching rule applies:
1. slot_valid[k] = 0 -> dout 0, dtype 0.
2. ZERO_REG = 1 and s == 0 -> dout 0, dtype 0.
3. Some slot j < k with slot_valid[j] = 1 and addr_rd[j] == s (and s != 0 when ZERO_REG = 1) -> dout = rd_tag of the highest such j, dtype 1.
4. Register s is valid -> dout = data[s], dtype 0.
5. BYPASS = 1 and a channel c has cdb_valid[c] = 1 and cdb_tag[c] == tag[s] -> dout = cdb_data[c] from the lowest such c, dtype 0.
6. Otherwise -> dout = tag[s] zero-extended, dtype 1.

Writes (posedge clk, en = 1, no flush), evaluated per register i:
- CDB resolve: applies when valid[i] = 0, tag[i] != 0, and a channel has cdb_valid = 1 with a tag equal to tag[i].
  - The lowest matching channel wins.
  - Effect: data <= that channel's data, valid <= 1, tag <= 0.
  - Channels with cdb_tag = 0 never match.
- Rename: applies when some slot has slot_valid = 1 and addr_rd == i (excluding register 0 when ZERO_REG = 1).
  - The highest-index such slot wins, since it is youngest.
  - Effect: valid <= 0, tag <= that slot's rd_tag.
  - Rename applies whether register i was valid or pending (WAW re-rename).
- Rename and resolve in the same cycle: rename wins on valid and tag; data takes the CDB value.

pending_count: combinational population count of valid = 0 bits. Register 0 never counts when ZERO_REG = 1.

No internal checking: duplicate tags across channels and rd_tag = 0 are producer errors, and behaviour is defined by the rules above.

Test Plan:
1. Reset, then with ISSUE_W = 2 read rs1 = 5, rs2 = 0 on slot 0 -> dout_rs1 = 5, dtype 0; dout_rs2 = 0, dtype 0; pending_count = 0.
2. Slot 0 renames rd = 7 with tag 0x12; same cycle, slot 1 reads rs1 = 7 -> slot 1 gets 0x12, dtype 1. Next cycle, read r7 -> tag 0x12, dtype 1; pending_count = 1.
3. r7 pending on tag 0x12; cdb_valid = 3'b010, cdb_tag[1] = 0x12, data 0xDEAD:
   - same-cycle read of r7 -> 0xDEAD, dtype 0 (bypass);
   - next cycle -> r7 valid with 0xDEAD, pending_count = 0.
4. r3 pending on tag 0x20; slot 0 renames r3 to 0x21 while the CDB broadcasts 0x20/0xBEEF -> r3 stays pending with tag 0x21, data = 0xBEEF. A later broadcast of 0x20 leaves r3 unchanged.
5. Both slots rename rd = 4 (tags 0x30 and 0x31) -> tag[4] = 0x31. Rename of rd = 0 with ZERO_REG = 1 -> r0 still reads 0, pending_count unchanged.
6. Three registers pending, assert flush with en = 1 and a matching CDB broadcast -> all valid, data unchanged (CDB ignored), pending_count = 0. Then assert reset and flush together -> data reloads to the index values.

Source files
------------

// File: rtl/rename_regfile_mp.sv
// Multi-port rename register file: architectural values plus per-register producer tags,
// with CDB resolve, intra-bundle forwarding, same-cycle CDB bypass and speculation flush.
module rename_regfile_mp #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 8,
  parameter int ISSUE_W  = 2,
  parameter int CDB_W    = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        flush,
  input  logic [ISSUE_W-1:0]          slot_valid,
  input  logic [ISSUE_W*ADDR_W-1:0]   addr_rs1,
  input  logic [ISSUE_W*ADDR_W-1:0]   addr_rs2,
  input  logic [ISSUE_W*ADDR_W-1:0]   addr_rd,
  input  logic [ISSUE_W*TAG_W-1:0]    rd_tag,
  output logic [ISSUE_W*DATA_W-1:0]   dout_rs1,
  output logic [ISSUE_W*DATA_W-1:0]   dout_rs2,
  output logic [ISSUE_W-1:0]          dtype_rs1,
  output logic [ISSUE_W-1:0]          dtype_rs2,
  input  logic [CDB_W-1:0]            cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
  input  logic [CDB_W*DATA_W-1:0]     cdb_data,
  output logic [CNT_W-1:0]            pending_count
);

  logic [DATA_W-1:0]   data_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_q   [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;

  logic [NUM_REGS-1:0] res_hit;
  logic [NUM_REGS-1:0] ren_hit;
  logic [DATA_W-1:0]   res_data [NUM_REGS];
  logic [TAG_W-1:0]    ren_tag  [NUM_REGS];

  // Returns {dtype, dout} for one source operand of slot k.
  function automatic logic [DATA_W:0] read_operand(input int k, input logic [ADDR_W-1:0] s);
    logic              fwd;
    logic [TAG_W-1:0]  fwd_tag;
    logic              byp;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W:0]   r;
    fwd      = 1'b0;
    fwd_tag  = '0;
    byp      = 1'b0;
    byp_data = '0;
    // Ascending scan: the youngest older slot writing s overrides earlier ones.
    for (int j = 0; j < ISSUE_W; j++) begin
      if (j < k && slot_valid[j] && addr_rd[j*ADDR_W +: ADDR_W] == s) begin
        fwd     = 1'b1;
        fwd_tag = rd_tag[j*TAG_W +: TAG_W];
      end
    end
    // Descending scan so the lowest matching channel is the one left standing.
    for (int c = CDB_W - 1; c >= 0; c--) begin
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag_q[s]) begin
        byp      = 1'b1;
        byp_data = cdb_data[c*DATA_W +: DATA_W];
      end
    end
    if (!slot_valid[k])                r = '0;
    else if (ZERO_REG != 0 && s == '0) r = '0;
    else if (fwd)                      r = {1'b1, DATA_W'(fwd_tag)};
    else if (valid_q[s])               r = {1'b0, data_q[s]};
    else if (BYPASS != 0 && byp)       r = {1'b0, byp_data};
    else                               r = {1'b1, DATA_W'(tag_q[s])};
    return r;
  endfunction

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    dout_rs1  = '0;
    dout_rs2  = '0;
    dtype_rs1 = '0;
    dtype_rs2 = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      {dtype_rs1[k], dout_rs1[k*DATA_W +: DATA_W]} = read_operand(k, addr_rs1[k*ADDR_W +: ADDR_W]);
      {dtype_rs2[k], dout_rs2[k*DATA_W +: DATA_W]} = read_operand(k, addr_rs2[k*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    res_hit = '0;
    ren_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      res_data[i] = '0;
      ren_tag[i]  = '0;
      // A zero tag marks "no producer", so it can never be resolved.
      for (int c = CDB_W - 1; c >= 0; c--) begin
        if (!valid_q[i] && tag_q[i] != '0 && cdb_valid[c] &&
            cdb_tag[c*TAG_W +: TAG_W] == tag_q[i]) begin
          res_hit[i]  = 1'b1;
          res_data[i] = cdb_data[c*DATA_W +: DATA_W];
        end
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        if (slot_valid[k] && addr_rd[k*ADDR_W +: ADDR_W] == ADDR_W'(i) &&
            !(ZERO_REG != 0 && i == 0)) begin
          ren_hit[i] = 1'b1;
          ren_tag[i] = rd_tag[k*TAG_W +: TAG_W];
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data array is reset entry by entry because each register has a defined reset value.
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]  <= DATA_W'(i);
        valid_q[i] <= 1'b1;
        tag_q[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        valid_q[i] <= 1'b1;
        tag_q[i]   <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (res_hit[i]) data_q[i] <= res_data[i];
        // A same-cycle rename keeps the register pending under the new tag.
        if (ren_hit[i]) begin
          valid_q[i] <= 1'b0;
          tag_q[i]   <= ren_tag[i];
        end else if (res_hit[i]) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= '0;
        end
      end
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!valid_q[i] && !(ZERO_REG != 0 && i == 0)) pending_count = pending_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Scoreboard bench for rename_regfile_mp: the driver queues expected read results per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_regfile_mp;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 8;
  localparam int ISSUE_W  = 2;
  localparam int CDB_W    = 3;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {K_RS1, K_RS2, K_PC} kind_e;
  typedef struct {
    string           name;
    kind_e           kind;
    int              slot;
    logic [DATA_W:0] value;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset, en, flush;
  logic [ISSUE_W-1:0]        slot_valid;
  logic [ISSUE_W*ADDR_W-1:0] addr_rs1, addr_rs2, addr_rd;
  logic [ISSUE_W*TAG_W-1:0]  rd_tag;
  logic [ISSUE_W*DATA_W-1:0] dout_rs1, dout_rs2;
  logic [ISSUE_W-1:0]        dtype_rs1, dtype_rs2;
  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*TAG_W-1:0]    cdb_tag;
  logic [CDB_W*DATA_W-1:0]   cdb_data;
  logic [CNT_W-1:0]          pending_count;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rename_regfile_mp #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W), .ISSUE_W(ISSUE_W),
    .CDB_W(CDB_W), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .slot_valid(slot_valid), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .addr_rd(addr_rd),
    .rd_tag(rd_tag), .dout_rs1(dout_rs1), .dout_rs2(dout_rs2),
    .dtype_rs1(dtype_rs1), .dtype_rs2(dtype_rs2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: reads settle half a cycle after the driver changes inputs.
  always @(negedge clk) begin
    exp_t it;
    logic [DATA_W:0] act;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        K_RS1:   act = {dtype_rs1[it.slot], dout_rs1[it.slot*DATA_W +: DATA_W]};
        K_RS2:   act = {dtype_rs2[it.slot], dout_rs2[it.slot*DATA_W +: DATA_W]};
        default: act = (DATA_W+1)'(pending_count);
      endcase
      check(it.name, act, it.value);
    end
  end

  task automatic idle();
    en = 1'b1; flush = 1'b0;
    slot_valid = '0; addr_rs1 = '0; addr_rs2 = '0; addr_rd = '0; rd_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic slot(input int k, input int rs1, input int rs2, input int rd, input int tag);
    slot_valid[k] = 1'b1;
    addr_rs1[k*ADDR_W +: ADDR_W] = ADDR_W'(rs1);
    addr_rs2[k*ADDR_W +: ADDR_W] = ADDR_W'(rs2);
    addr_rd[k*ADDR_W +: ADDR_W]  = ADDR_W'(rd);
    rd_tag[k*TAG_W +: TAG_W]     = TAG_W'(tag);
  endtask

  task automatic cdb(input int c, input int tag, input logic [DATA_W-1:0] data);
    cdb_valid[c] = 1'b1;
    cdb_tag[c*TAG_W +: TAG_W]    = TAG_W'(tag);
    cdb_data[c*DATA_W +: DATA_W] = data;
  endtask

  task automatic exp_op(input string name, input kind_e kind, input int k,
                        input logic dtype, input logic [DATA_W-1:0] value);
    exp_t it;
    it.name = name; it.kind = kind; it.slot = k; it.value = {dtype, value};
    sb_q.push_back(it);
  endtask

  task automatic exp_pc(input string name, input int value);
    exp_t it;
    it.name = name; it.kind = K_PC; it.slot = 0; it.value = (DATA_W+1)'(value);
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset values, zero register, invalid slot
    slot(0, 5, 0, 0, 0);
    addr_rs1[ADDR_W +: ADDR_W] = 5'd9;
    exp_op("rst_r5", K_RS1, 0, 1'b0, 32'd5);
    exp_op("rst_r0", K_RS2, 0, 1'b0, 32'd0);
    exp_op("inv_slot", K_RS1, 1, 1'b0, 32'd0);
    exp_pc("rst_pc", 0);
    step();

    // Rename r7 -> 0x12 with intra-bundle forward to slot 1
    slot(0, 1, 2, 7, 'h12);
    slot(1, 7, 3, 0, 0);
    exp_op("s0_r1", K_RS1, 0, 1'b0, 32'd1);
    exp_op("s0_r2", K_RS2, 0, 1'b0, 32'd2);
    exp_op("fwd_r7", K_RS1, 1, 1'b1, 32'h12);
    exp_op("s1_r3", K_RS2, 1, 1'b0, 32'd3);
    step();

    // r7 pending; en=0 blocks a rename of r9
    en = 1'b0;
    slot(0, 7, 6, 0, 0);
    slot(1, 7, 7, 9, 'h40);
    exp_op("pend_r7", K_RS1, 0, 1'b1, 32'h12);
    exp_op("r6", K_RS2, 0, 1'b0, 32'd6);
    exp_pc("pc_1", 1);
    step();

    // CDB bypass on channel 1; channel 0 carries an unrelated tag
    slot(0, 7, 9, 0, 0);
    cdb(0, 'h55, 32'h1111);
    cdb(1, 'h12, 32'hDEAD);
    exp_op("byp_r7", K_RS1, 0, 1'b0, 32'hDEAD);
    exp_op("en0_r9", K_RS2, 0, 1'b0, 32'd9);
    exp_pc("pc_en0", 1);
    step();

    // r7 resolved; rename r3 -> 0x20
    slot(0, 7, 0, 3, 'h20);
    slot(1, 3, 0, 0, 0);
    exp_op("res_r7", K_RS1, 0, 1'b0, 32'hDEAD);
    exp_op("fwd_r3", K_RS1, 1, 1'b1, 32'h20);
    exp_pc("pc_res", 0);
    step();

    // WAW re-rename r3 -> 0x21 while 0x20 broadcasts
    slot(0, 3, 0, 3, 'h21);
    slot(1, 3, 0, 0, 0);
    cdb(0, 'h20, 32'hBEEF);
    exp_op("byp_r3", K_RS1, 0, 1'b0, 32'hBEEF);
    exp_op("fwd_r3b", K_RS1, 1, 1'b1, 32'h21);
    exp_pc("pc_r3", 1);
    step();

    // Stale 0x20 broadcast must not resolve r3
    slot(0, 3, 0, 0, 0);
    cdb(2, 'h20, 32'hCAFE);
    exp_op("waw_r3", K_RS1, 0, 1'b1, 32'h21);
    exp_pc("pc_waw", 1);
    step();

    // Both slots rename r4; youngest must win
    slot(0, 3, 0, 4, 'h30);
    slot(1, 4, 0, 4, 'h31);
    exp_op("stale_r3", K_RS1, 0, 1'b1, 32'h21);
    exp_op("fwd_r4", K_RS1, 1, 1'b1, 32'h30);
    step();

    // Rename of r0 is ignored
    slot(0, 4, 0, 0, 'h44);
    slot(1, 0, 4, 0, 'h45);
    exp_op("waw_r4", K_RS1, 0, 1'b1, 32'h31);
    exp_op("zero_s1", K_RS1, 1, 1'b0, 32'd0);
    exp_op("r4_s1", K_RS2, 1, 1'b1, 32'h31);
    exp_pc("pc_2", 2);
    step();

    // r0 still zero; r4 resolves, lowest channel wins
    slot(0, 0, 0, 0, 0);
    slot(1, 4, 0, 0, 0);
    cdb(1, 'h31, 32'h5555);
    cdb(2, 'h31, 32'h4444);
    exp_op("r0_zero", K_RS1, 0, 1'b0, 32'd0);
    exp_op("low_ch", K_RS1, 1, 1'b0, 32'h5555);
    exp_pc("pc_r0", 2);
    step();

    // Rename r10/r11 -> three pending
    slot(0, 4, 0, 10, 'h50);
    slot(1, 0, 0, 11, 'h51);
    exp_op("res_r4", K_RS1, 0, 1'b0, 32'h5555);
    step();

    // Flush with a matching CDB and a rename: both ignored
    flush = 1'b1;
    slot(0, 10, 0, 12, 'h60);
    cdb(0, 'h21, 32'h9999);
    exp_op("pre_fl_r10", K_RS1, 0, 1'b1, 32'h50);
    exp_pc("pc_3", 3);
    step();

    slot(0, 3, 12, 0, 0);
    slot(1, 10, 7, 0, 0);
    exp_op("fl_r3", K_RS1, 0, 1'b0, 32'hBEEF);
    exp_op("fl_r12", K_RS2, 0, 1'b0, 32'd12);
    exp_op("fl_r10", K_RS1, 1, 1'b0, 32'd10);
    exp_op("fl_r7", K_RS2, 1, 1'b0, 32'hDEAD);
    exp_pc("fl_pc", 0);
    step();

    // Pend r7, then reset together with flush
    slot(0, 0, 0, 7, 'h70);
    step();
    reset = 1'b1;
    flush = 1'b1;
    exp_pc("pc_pre_rst", 1);
    step();
    reset = 1'b0;

    slot(0, 7, 3, 0, 0);
    exp_op("rst2_r7", K_RS1, 0, 1'b0, 32'd7);
    exp_op("rst2_r3", K_RS2, 0, 1'b0, 32'd3);
    exp_pc("rst2_pc", 0);
    step();
    step();

    check("sb_drained", (DATA_W+1)'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
